// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner selection for one shared 4-digit
// seven-segment display. Three requesters use a level req/grant handshake.
// Each grant is held for at least HOLD_CYCLES cycles so that the shown value
// stays readable before another source takes the display.
//
// Optional feature macro: SEG_ARB_ROTATE_EN
//   defined   - an owner that is still requesting is preempted once its hold
//               time has expired and another requester is pending, so the
//               display time-slices between the active sources.
//   undefined - an owner keeps the display for as long as its req stays high.
//
// state  | meaning
// IDLE   | no owner, display not valid
// ACTIVE | owner's req is high, disp_value tracks the owner's data
// LINGER | owner dropped req before its hold expired, disp_value frozen
module seg_display_arbiter #(
    parameter int          HOLD_CYCLES = 50_000_000,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  grant,
    output logic [15:0] disp_value,
    output logic        disp_valid
);

    localparam int            CW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LINGER = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    last;
    logic [CW-1:0] cnt;

    logic          hold_done;
    logic [CW-1:0] cnt_inc;
    logic          owner_req;
    logic [15:0]   owner_data;
    logic [2:0]    pick_all;
    logic          take;
    logic [1:0]    take_idx;
    logic          to_idle;

    // Search order starts after the most recent owner and wraps 2 -> 0.
    // Result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [1:0] from, input logic [2:0] mask);
        logic [1:0] idx;
        rr_pick = 3'b000;
        idx     = from;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!rr_pick[2] && mask[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    function automatic logic [15:0] data_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    data_sel = data0;
            2'd1:    data_sel = data1;
            default: data_sel = data2;
        endcase
    endfunction

    assign hold_done  = (cnt == CNT_MAX);
    assign cnt_inc    = hold_done ? cnt : cnt + 1'b1;
    assign owner_req  = req[last];
    assign owner_data = data_sel(last);
    assign pick_all   = rr_pick(last, req);

`ifdef SEG_ARB_ROTATE_EN
    logic [2:0] pick_other;
    // While the owner is in place, grant mirrors its one-hot index.
    assign pick_other = rr_pick(last, req & ~grant);
`endif

    // Decide whether this edge hands the display to a new owner or releases it.
    always_comb begin
        take     = 1'b0;
        take_idx = pick_all[1:0];
        to_idle  = 1'b0;
        case (state)
            IDLE: begin
                take = pick_all[2];
            end
            ACTIVE: begin
                if (owner_req) begin
`ifdef SEG_ARB_ROTATE_EN
                    if (hold_done && pick_other[2]) begin
                        take     = 1'b1;
                        take_idx = pick_other[1:0];
                    end
`endif
                end else if (hold_done) begin
                    take    = pick_all[2];
                    to_idle = !pick_all[2];
                end
            end
            LINGER: begin
                // Once the hold expires the old owner competes like anyone else.
                if (hold_done) begin
                    take    = pick_all[2];
                    to_idle = !pick_all[2];
                end
            end
            default: to_idle = 1'b1;
        endcase
    end

    // Arbiter FSM with registered grant, display value and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= 2'd2;
            cnt        <= '0;
            grant      <= 3'b000;
            disp_value <= IDLE_VALUE;
            disp_valid <= 1'b0;
        end else if (take) begin
            state      <= ACTIVE;
            last       <= take_idx;
            cnt        <= '0;
            grant      <= 3'(3'b001 << take_idx);
            disp_value <= data_sel(take_idx);
            disp_valid <= 1'b1;
        end else if (to_idle) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= 3'b000;
            disp_valid <= 1'b0;
        end else begin
            case (state)
                ACTIVE: begin
                    cnt <= cnt_inc;
                    if (owner_req) disp_value <= owner_data;
                    else           state      <= LINGER;
                end
                LINGER: begin
                    cnt <= cnt_inc;
                    if (owner_req) begin
                        state      <= ACTIVE;
                        disp_value <= owner_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios followed by random
// request/data traffic, all compared against an ownership/age model.
module tb_seg_display_arbiter;

    localparam int          H    = 4;
    localparam logic [15:0] IDLE = 16'hBEEF;
`ifdef SEG_ARB_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [15:0] data0 = 16'h0, data1 = 16'h0, data2 = 16'h0;
    logic [2:0]  grant;
    logic [15:0] disp_value;
    logic        disp_valid;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: who owns the display, how many cycles it has owned it.
    int          m_owner;
    int          m_age;
    bit          m_ling;
    int          m_last;
    logic [15:0] m_val;
    bit          m_valid;

    seg_display_arbiter #(.HOLD_CYCLES(H), .IDLE_VALUE(IDLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .grant      (grant),
        .disp_value (disp_value),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int pick(input int from, input logic [2:0] m);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (from + k) % 3;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] dsel(input int i);
        return (i == 0) ? data0 : (i == 1) ? data1 : data2;
    endfunction

    task automatic m_reset();
        m_owner = -1; m_age = 0; m_ling = 0; m_last = 2; m_val = IDLE; m_valid = 0;
    endtask

    task automatic m_take(input int p);
        m_owner = p; m_age = 1; m_ling = 0; m_last = p; m_val = dsel(p); m_valid = 1;
    endtask

    task automatic m_release();
        m_owner = -1; m_ling = 0; m_valid = 0;
    endtask

    // One rising edge of the model, using the inputs currently applied.
    task automatic m_step();
        int  p;
        bit  done;
        if (m_owner < 0) begin
            p = pick(m_last, req);
            if (p >= 0) m_take(p);
        end else begin
            done = (m_age >= H);
            if (m_ling && done) begin
                p = pick(m_last, req);
                if (p >= 0) m_take(p); else m_release();
            end else if (req[m_owner]) begin
                p = (ROT && done) ? pick(m_last, req & ~(3'(1 << m_owner))) : -1;
                if (p >= 0) m_take(p);
                else begin
                    m_ling = 0; m_val = dsel(m_owner); m_age++;
                end
            end else if (!done) begin
                m_ling = 1; m_age++;
            end else begin
                p = pick(m_last, req);
                if (p >= 0) m_take(p); else m_release();
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".grant"}, 32'(grant), (m_owner < 0) ? 32'h0 : 32'(1 << m_owner));
        chk({tag, ".value"}, 32'(disp_value), 32'(m_val));
        chk({tag, ".valid"}, 32'(disp_valid), 32'(m_valid));
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic step(input string tag);
        @(posedge clk);
        m_step();
        #1;
        compare(tag);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic apply_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.value", 32'(disp_value), 32'(IDLE));
        chk("rst.valid", 32'(disp_valid), 32'h0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        #22;
        chk("por.grant", 32'(grant), 32'h0);
        chk("por.value", 32'(disp_value), 32'(IDLE));
        chk("por.valid", 32'(disp_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from IDLE
        req = 3'b010; data1 = 16'h1234;
        step("first");
        chk("first.grant_k", 32'(grant), 32'h2);
        chk("first.value_k", 32'(disp_value), 32'h1234);
        req = 3'b000;
        for (int i = 0; i < 6; i++) step("release");
        apply_reset();

        // All three request together
        req = 3'b111; data0 = 16'hA000; data1 = 16'hB111; data2 = 16'hC222;
        step("rr");
        chk("rr.first", 32'(grant), 32'h1);
        for (int i = 0; i < 4; i++) step("rr");
        chk("rr.second", 32'(grant), ROT ? 32'h2 : 32'h1);
        for (int i = 0; i < 8; i++) step("rr");
        apply_reset();

        // Owner drops early while its data changes: linger then idle
        req = 3'b001; data0 = 16'h5A5A;
        step("linger");
        step("linger");
        req = 3'b000; data0 = 16'hFFFF;
        for (int i = 0; i < 5; i++) step("linger");
        chk("linger.kept", 32'(disp_value), 32'h5A5A);
        apply_reset();

        // Owner 2 drops exactly at hold expiry with req[0] pending
        req = 3'b100; data2 = 16'h2222; data0 = 16'h0F0F;
        for (int i = 0; i < 4; i++) step("handover");
        req = 3'b001;
        step("handover");
        chk("handover.k", 32'(grant), 32'h1);
        chk("handover.v", 32'(disp_valid), 32'h1);

        // Owner data increments every cycle
        apply_reset();
        req = 3'b010; data1 = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            step("track");
            data1 = data1 + 16'h1;
        end

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 1) == 1) data0 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) data1 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) data2 = 16'($urandom);
            if ($urandom_range(0, 199) == 0) apply_reset();
            else step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
